// File: rtl/cu_sequencer.sv
`default_nettype none
// cu_sequencer: holds the control-unit state register, IR and status flags.
// It decodes the selected control word and stalls memory accesses until mem_ready arrives.
module cu_sequencer #(
  parameter int          CUL         = 36,
  parameter int          MEM_TIMEOUT = 15,
  parameter logic [3:0]  HALT_STATE  = 4'hF
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [CUL:0]  cw_in,
  input  logic [3:0]    ns_in,
  input  logic          mem_ready,
  input  logic [31:0]   ir_bus,
  input  logic [3:0]    status_in,
  output logic [3:0]    state,
  output logic [31:0]   IR,
  output logic [3:0]    status,
  output logic [4:0]    FS,
  output logic [4:0]    SA,
  output logic [4:0]    SB,
  output logic [4:0]    DA,
  output logic          w_reg,
  output logic          C0,
  output logic [1:0]    mem_cs,
  output logic          B_Sel,
  output logic          mem_write_en,
  output logic [1:0]    size,
  output logic          add_tri_sel,
  output logic [1:0]    data_tri_sel,
  output logic          PC_sel,
  output logic [1:0]    PC_FS,
  output logic          stall,
  output logic          mem_err,
  output logic          halted
);

  localparam logic [1:0] S_RUN  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

  localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

  logic [1:0] fsm;
  logic [7:0] wait_cnt;
  logic       mem_access;
  logic       gated;
  logic       status_load;
  logic       ir_load;
  logic       unused_reserved;

  assign unused_reserved = cw_in[CUL];

  assign mem_access  = (cw_in[13:12] != 2'b00);
  assign halted      = (fsm == S_HALT);
  assign stall       = mem_access & ~mem_ready & ~halted & ~reset;
  assign gated       = stall | halted | reset;
  assign status_load = cw_in[8];
  assign ir_load     = cw_in[9];

  assign PC_FS        = gated ? 2'b00 : cw_in[1:0];
  assign PC_sel       = cw_in[2];
  assign data_tri_sel = cw_in[4:3];
  assign add_tri_sel  = cw_in[5];
  assign size         = cw_in[7:6];
  assign mem_write_en = gated ? 1'b0 : cw_in[10];
  assign B_Sel        = cw_in[11];
  assign mem_cs       = halted ? 2'b00 : cw_in[13:12];
  assign C0           = cw_in[14];
  assign w_reg        = gated ? 1'b0 : cw_in[15];
  assign DA           = cw_in[20:16];
  assign SB           = cw_in[25:21];
  assign SA           = cw_in[30:26];
  assign FS           = cw_in[35:31];

  always_ff @(posedge clock) begin
    if (reset) begin
      fsm      <= S_RUN;
      state    <= 4'h0;
      IR       <= 32'h0;
      status   <= 4'h0;
      wait_cnt <= 8'h0;
      mem_err  <= 1'b0;
    end else if (fsm != S_HALT) begin
      if (stall) begin
        // Timeout abandons the access and restarts at fetch without loading.
        if (wait_cnt == TIMEOUT_LAST) begin
          mem_err  <= 1'b1;
          state    <= 4'h0;
          wait_cnt <= 8'h0;
          fsm      <= S_RUN;
        end else begin
          wait_cnt <= wait_cnt + 8'd1;
          fsm      <= S_WAIT;
        end
      end else begin
        if (ir_load)     IR     <= ir_bus;
        if (status_load) status <= status_in;
        wait_cnt <= 8'h0;
        state    <= ns_in;
        fsm      <= (ns_in == HALT_STATE) ? S_HALT : S_RUN;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/cu_sequencer.md
Name: cu_sequencer

Overview:
- Consumer side of the per-state control-unit modules.
- Each cycle it takes the control word and next-state value produced by the state module selected by the current state, and holds the state register.
- Owns the IR and status-flag registers; it loads them from the control word's IR_load and status_load bits.
- Splits the control word into datapath fields and stalls the sequence while a memory access waits for mem_ready. Detects memory timeouts and halt.

Parameters:
- CUL, 36: MSB index of the control word (word width CUL+1 = 37).
- MEM_TIMEOUT, 15: maximum stall cycles before a memory access is aborted; range 1..255.
- HALT_STATE, 4'hF: ns_in value that parks the sequencer.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- cw_in  input  CUL+1  control word from the selected state module.
- ns_in  input  4  next-state request from the selected state module.
- mem_ready  input  1  memory handshake; access completes in the cycle it is high.
- ir_bus  input  32  instruction data from the memory data bus.
- status_in  input  4  ALU flags.
- state  output  4  current state; drives the state-module mux select.
- IR  output  32  instruction register.
- status  output  4  latched flags.
- FS  output  5  ALU function select.
- SA  output  5  register source A.
- SB  output  5  register source B.
- DA  output  5  register destination.
- w_reg  output  1  register write enable, gated.
- C0  output  1  carry in.
- mem_cs  output  2  memory chip select.
- B_Sel  output  1  B operand select.
- mem_write_en  output  1  memory write enable, gated.
- size  output  2  access size.
- add_tri_sel  output  1  address tri-state select.
- data_tri_sel  output  2  data tri-state select.
- PC_sel  output  1  PC source select.
- PC_FS  output  2  PC function, gated.
- stall  output  1  memory wait in progress.
- mem_err  output  1  sticky timeout flag.
- halted  output  1  sequencer parked.

Behaviour:
- Control word field map (LSB first):
  - PC_FS [1:0], PC_sel [2], data_tri_sel [4:3], add_tri_sel [5], size [7:6]
  - status_load [8], IR_load [9], mem_write_en [10], B_Sel [11], mem_cs [13:12]
  - C0 [14], w_reg [15], DA [20:16], SB [25:21], SA [30:26], FS [35:31]
  - Bit 36 is reserved and ignored.
- Field outputs are combinational from cw_in, with these exceptions:
  - w_reg, mem_write_en and PC_FS are forced to 0 in the cycles listed below (gated cycles).
  - When halted, mem_cs is also 0.
- Memory access condition: mem_access = (mem_cs != 2'b00).
- stall = mem_access & ~mem_ready & ~halted.
- States of the sequencer FSM:
  - RUN: state <= ns_in on each non-stalled edge.
  - WAIT: entered on the first stalled cycle; wait counter increments each stalled cycle; state is held.
  - HALT.
- WAIT rules:
  - Gated cycles are every stalled cycle: w_reg, mem_write_en and PC_FS are 0; IR and status are not loaded.
  - mem_ready high: the access completes that cycle. Loads and gates apply normally, state <= ns_in, counter clears, return to RUN.
  - Counter reaches MEM_TIMEOUT with mem_ready low: mem_err <= 1, state <= 4'h0 (fetch), counter clears, return to RUN. IR and status are not loaded.
- Loads happen on a non-stalled edge:
  - IR_load = 1: IR <= ir_bus.
  - status_load = 1: status <= status_in.
  - Both may load in the same cycle.
- Non-memory states never stall; their latency is one cycle per state.
- Halt:
  - ns_in == HALT_STATE on a non-stalled edge: state <= HALT_STATE and halted <= 1.
  - Thereafter state is held, all gated outputs and mem_cs are 0, and loads are suppressed until reset.
- mem_err is sticky until reset and does not stop sequencing.
- Reset (synchronous, dominates all other inputs, including in WAIT):
  - state = 4'h0, IR = 0, status = 0, wait counter = 0.
  - mem_err = 0, halted = 0.
  - In the reset cycle, stall and all gated outputs read 0.
- mem_ready with mem_cs == 00 is ignored.
- ns_in equal to the current state is legal (self-loop).

Test Plan:
- Fetch, immediate ready:
  - Stimulus: reset, then cw_in = fetch word (mem_cs=10, IR_load=1, size=11, add_tri=1, data_tri=11), ns_in=1, mem_ready=1, ir_bus=32'h8B020041.
  - Required: after 1 edge IR=32'h8B020041, state=1, stall never high.
- Fetch with 3 wait cycles:
  - Stimulus: same word, mem_ready low for 3 cycles then high.
  - Required: stall=1 for 3 cycles; state and IR unchanged during stall; IR and state update on the 4th edge.
- Timeout:
  - Stimulus: MEM_TIMEOUT=4, mem_ready held low, current state=2.
  - Required: after 4 stalled cycles mem_err=1 and state=0; IR unchanged; mem_err stays 1 through later normal fetches.
- Gating:
  - Stimulus: cw_in with w_reg=1, mem_write_en=1, PC_FS=01, mem_cs=01, mem_ready=0.
  - Required: w_reg, mem_write_en and PC_FS outputs all 0 while stalled; they read 1, 1 and 01 in the completion cycle.
- Status load and field decode:
  - Stimulus: cw_in with FS=5'h13, SA=3, SB=7, DA=9, status_load=1, status_in=4'b1010, mem_cs=00.
  - Required: field outputs match immediately; status=4'b1010 after 1 edge; no stall.
- Halt and reset mid-wait:
  - Stimulus: ns_in=4'hF.
  - Required: halted=1, state=F, mem_cs output 0, ignores ns_in afterwards.
  - Stimulus: then a stall in progress with reset asserted for 1 cycle.
  - Required: all registers return to their reset values, state=0, halted=0.
